cpu_imem_arbiter: RTL and testbench
===================================

Name: cpu_imem_arbiter

Overview:
- Shares the CPU's single-port program/data memory between two requesters:
  - the CPU fetch/data port;
  - a program loader, which writes the instruction image at run time.
- Grants one access per cycle with round-robin arbitration.
- Supports loader burst lock with a bounded lock time, and raises a stall to the CPU while a load session is active.
- Sits between the cpu core, the loader, and the 16x8 instruction memory.

Parameters:
- ADDR_W, 4, memory address width (matches the 4-bit PC)
- DATA_W, 8, memory word width (4-bit opcode + 4-bit operand)
- LOCK_MAX, 8, maximum consecutive loader grants under lock while the CPU is pending

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- cpu_stall  out  1  hold CPU pipeline/state (loader session active)
- ldr_req  in  1  loader access request; held until ldr_gnt
- ldr_we  in  1  1 = write, 0 = read
- ldr_addr  in  ADDR_W  loader address
- ldr_wdata  in  DATA_W  loader write data
- ldr_lock  in  1  loader burst lock request
- ldr_gnt  out  1  loader access issued this cycle
- ldr_rvalid  out  1  loader read data valid
- ldr_rdata  out  DATA_W  loader read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0
- conflict_cnt  out  16  count of contended cycles (see Optional Feature)

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, state IDLE, rr pointer favours CPU, lock counter 0, pending read tags cleared.
- State machine (owner of the current memory cycle):
  - IDLE → CPU or LDR on any request.
  - CPU/LDR → next owner re-decided every clock.
  - → IDLE when no request.
- Timing:
  - Requests sampled at edge N.
  - Grant, mem_en and the mem_* fields are registered and appear in cycle N+1.
  - For reads, rvalid and rdata to the granted requester appear in cycle N+2, single-cycle pulse.
  - Writes produce no rvalid.
- Exactly one of cpu_gnt/ldr_gnt is high per cycle, or neither; mem_en = cpu_gnt | ldr_gnt.
- Requester protocol:
  - req and its fields are held stable until gnt.
  - A requester may keep req high after gnt for back-to-back accesses, one per cycle when uncontended.
- Arbitration when both request, no lock: round robin; the requester not granted last wins.
- Lock:
  - If ldr_lock=1 and the loader holds req, the loader wins ties.
  - The lock counter increments per loader grant while cpu_req=1.
  - When the counter reaches LOCK_MAX, the next contended cycle is forced to the CPU and the counter clears.
  - The counter clears whenever ldr_lock=0 or cpu_req=0.
- cpu_stall = registered ldr_lock: asserts 1 cycle after ldr_lock rises and drops 1 cycle after it falls.
  - CPU requests still arbitrate while stalled; stall is advisory to the core's FSM.
- Read tag: a 1-bit owner tag registered with the grant routes mem_rdata to the correct rdata/rvalid. Grant to A then B gives rvalid_A then rvalid_B in consecutive cycles.
- rdata holds its last value when rvalid=0.
- Reset mid-operation: outstanding reads are dropped (no rvalid after reset release) and the requester must re-request.
- Same-address write then read from different requesters in consecutive grants: the read returns the new data (memory is write-first by ordering).

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - conflict_cnt increments in each cycle with cpu_req=1 and ldr_req=1 at the sampling edge.
  - Saturates at 0xFFFF and clears on reset.
- Undefined: conflict_cnt is constant 0 and no counter logic is built.

Test Plan:
- Reset low mid-run → all outputs 0 immediately; after release with no requests, mem_en stays 0.
- Memory[3]=0x5A; cpu_req, read, addr 3 at edge 0 → cpu_gnt and mem_addr=3 in cycle 1; cpu_rvalid=1 and cpu_rdata=0x5A in cycle 2; ldr outputs stay 0.
- Both request continuously, ldr_lock=0, for 6 cycles → grants alternate CPU, LDR, CPU, LDR, CPU, LDR; never both high.
- ldr_lock=1, loader writes addr 0..15 with cpu_req held, LOCK_MAX=8:
  - 8 ldr_gnt, then 1 cpu_gnt, then 8 ldr_gnt.
  - cpu_stall is high from 1 cycle after lock rises.
  - Readback of all 16 words matches.
- CPU read granted, then reset low in the following cycle → no cpu_rvalid ever appears; a re-request after release completes normally.
- With ARB_STATS_EN, 10 contended cycles → conflict_cnt=10. Without the macro → conflict_cnt=0.

Source files
------------

// File: rtl/cpu_imem_arbiter.sv
// Round-robin arbiter sharing the single-port instruction memory between the CPU and the program loader.
// Optional contention statistics are built when the ARB_STATS_EN macro is defined.
module cpu_imem_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_LDR} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_prio_ldr, w_prio_ldr_nxt;
  logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_stall;
  logic              r_rd_pend;
  logic              r_rd_ldr;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              w_both;

  assign w_both = cpu_req & ldr_req;

  // Next owner is re-decided every clock; r_state is the owner of the cycle in flight.
  always_comb begin
    w_state_nxt    = S_IDLE;
    w_prio_ldr_nxt = r_prio_ldr;
    w_lock_cnt_nxt = r_lock_cnt;
    if (w_both) begin
      if (ldr_lock)
        w_state_nxt = (r_lock_cnt == LOCK_LIM) ? S_CPU : S_LDR;
      else
        w_state_nxt = r_prio_ldr ? S_LDR : S_CPU;
    end else if (cpu_req) begin
      w_state_nxt = S_CPU;
    end else if (ldr_req) begin
      w_state_nxt = S_LDR;
    end
    if (w_state_nxt == S_CPU)
      w_prio_ldr_nxt = 1'b1;
    else if (w_state_nxt == S_LDR)
      w_prio_ldr_nxt = 1'b0;
    // Counter tracks loader wins while the CPU waits; a forced CPU win restarts the window.
    if (!ldr_lock || !cpu_req)
      w_lock_cnt_nxt = '0;
    else if (w_state_nxt == S_LDR)
      w_lock_cnt_nxt = r_lock_cnt + 1'b1;
    else if (w_both)
      w_lock_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_prio_ldr  <= 1'b0;
      r_lock_cnt  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_stall     <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_ldr    <= 1'b0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio_ldr <= w_prio_ldr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_stall    <= ldr_lock;
      case (w_state_nxt)
        S_CPU: begin
          r_mem_we    <= cpu_we;
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
        end
        S_LDR: begin
          r_mem_we    <= ldr_we;
          r_mem_addr  <= ldr_addr;
          r_mem_wdata <= ldr_wdata;
        end
        default: r_mem_we <= 1'b0;
      endcase
      // Owner tag follows the read into the cycle where the memory returns data.
      r_rd_pend <= mem_en & ~mem_we;
      r_rd_ldr  <= ldr_gnt;
      if (cpu_rvalid) r_cpu_rdata <= mem_rdata;
      if (ldr_rvalid) r_ldr_rdata <= mem_rdata;
    end
  end

  assign cpu_gnt    = (r_state == S_CPU);
  assign ldr_gnt    = (r_state == S_LDR);
  assign mem_en     = cpu_gnt | ldr_gnt;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_stall  = r_stall;
  assign cpu_rvalid = r_rd_pend & ~r_rd_ldr;
  assign ldr_rvalid = r_rd_pend & r_rd_ldr;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : r_cpu_rdata;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : r_ldr_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_conflict_cnt <= '0;
    else if (w_both && !(&r_conflict_cnt))
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_imem_arbiter.sv
// Bench for cpu_imem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_cpu_imem_arbiter;
  localparam int ADDR_W = 4, DATA_W = 8, LOCK_MAX = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid, mem_en, mem_we;
  logic [DATA_W-1:0] cpu_rdata, ldr_rdata, mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] conflict_cnt;

  int n_checks = 0, n_fail = 0;

  cpu_imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory, read data one cycle after the access.
  logic [DATA_W-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Reference model state: who owns the cycle, what it does, what comes back.
  logic [DATA_W-1:0] shadow [16];
  logic e_cpu_gnt, e_ldr_gnt, e_we, e_cpu_rv, e_ldr_rv, e_stall;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_cpu_rdata, e_ldr_rdata;
  bit   last_was_ldr;
  int   ldr_streak, e_conf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] img(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  task automatic model_reset();
    e_cpu_gnt = 0; e_ldr_gnt = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_cpu_rv = 0; e_ldr_rv = 0; e_cpu_rdata = '0; e_ldr_rdata = '0; e_stall = 0;
    last_was_ldr = 1'b1;
    ldr_streak = 0; e_conf = 0;
  endtask

  task automatic model_step();
    bit win_c, win_l, both;
    e_cpu_rv = 0; e_ldr_rv = 0;
    if (e_cpu_gnt || e_ldr_gnt) begin
      if (e_we) shadow[e_addr] = e_wdata;
      else if (e_cpu_gnt) begin e_cpu_rv = 1; e_cpu_rdata = shadow[e_addr]; end
      else begin e_ldr_rv = 1; e_ldr_rdata = shadow[e_addr]; end
    end
    both = cpu_req && ldr_req;
    win_c = 0; win_l = 0;
    if (both) begin
      if (e_conf < 65535) e_conf++;
      if (ldr_lock) begin
        if (ldr_streak >= LOCK_MAX) win_c = 1; else win_l = 1;
      end else if (last_was_ldr) win_c = 1;
      else win_l = 1;
    end else begin
      win_c = cpu_req; win_l = ldr_req;
    end
    if (!ldr_lock || !cpu_req) ldr_streak = 0;
    else if (win_l) ldr_streak++;
    else if (both) ldr_streak = 0;
    if (win_c) last_was_ldr = 0;
    if (win_l) last_was_ldr = 1;
    e_cpu_gnt = win_c; e_ldr_gnt = win_l;
    if (win_c) begin e_we = cpu_we; e_addr = cpu_addr; e_wdata = cpu_wdata; end
    if (win_l) begin e_we = ldr_we; e_addr = ldr_addr; e_wdata = ldr_wdata; end
    e_stall = ldr_lock;
  endtask

  task automatic check_all();
    logic en;
    int conf_exp;
    en = e_cpu_gnt | e_ldr_gnt;
`ifdef ARB_STATS_EN
    conf_exp = e_conf;
`else
    conf_exp = 0;
`endif
    check("cpu_gnt", 32'(cpu_gnt), 32'(e_cpu_gnt));
    check("ldr_gnt", 32'(ldr_gnt), 32'(e_ldr_gnt));
    check("gnt_onehot", 32'(cpu_gnt & ldr_gnt), 32'(0));
    check("mem_en", 32'(mem_en), 32'(en));
    check("mem_we", 32'(mem_we), 32'(en & e_we));
    if (en) check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (en && e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cpu_rv));
    check("ldr_rvalid", 32'(ldr_rvalid), 32'(e_ldr_rv));
    check("cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
    check("ldr_rdata", 32'(ldr_rdata), 32'(e_ldr_rdata));
    check("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    check("conflict_cnt", 32'(conflict_cnt), 32'(conf_exp));
  endtask

  // One clock: model observes the sampling edge, outputs are checked at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; ldr_req = 0; ldr_we = 0; ldr_lock = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    int idx, ng;
    bit g_ldr [17];
    model_reset();
    idle_inputs();
    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    reset = 1;
    repeat (2) cyc();

    // CPU writes 0x5A to address 3, then reads it back
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd3; cpu_wdata = 8'h5A;
    cyc();
    cpu_req = 0;
    cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
    cyc();
    check("rd3_gnt", 32'(cpu_gnt), 32'(1));
    check("rd3_addr", 32'(mem_addr), 32'(3));
    cpu_req = 0;
    cyc();
    check("rd3_rvalid", 32'(cpu_rvalid), 32'(1));
    check("rd3_rdata", 32'(cpu_rdata), 32'h5A);
    check("rd3_ldr_rvalid", 32'(ldr_rvalid), 32'(0));
    check("rd3_ldr_gnt", 32'(ldr_gnt), 32'(0));
    cyc();

    // Round robin alternation, starting from the reset pointer
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 4'd1; cpu_wdata = 8'h11;
    ldr_req = 1; ldr_we = 1; ldr_addr = 4'd2; ldr_wdata = 8'h22;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("rr_cpu", 32'(cpu_gnt), 32'(i % 2 == 0));
      check("rr_ldr", 32'(ldr_gnt), 32'(i % 2 == 1));
    end
    idle_inputs();
    cyc();

    // Locked loader burst of 16 writes while the CPU keeps reading
    idx = 0; ng = 0;
    ldr_lock = 1; ldr_req = 1; ldr_we = 1; ldr_addr = 4'd0; ldr_wdata = img(0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd3;
    for (int c = 0; c < 40 && ng < 17; c++) begin
      cyc();
      if (c == 0) check("stall_rise", 32'(cpu_stall), 32'(1));
      if (cpu_gnt || ldr_gnt) begin
        g_ldr[ng] = ldr_gnt;
        ng++;
      end
      if (ldr_gnt) begin
        idx++;
        if (idx == 16) ldr_req = 0;
        else begin ldr_addr = 4'(idx); ldr_wdata = img(idx); end
      end
    end
    check("lock_grants", 32'(ng), 32'(17));
    for (int i = 0; i < 17; i++) check("lock_seq", 32'(g_ldr[i]), 32'(i != 8));
    check("lock_writes", 32'(idx), 32'(16));
    idle_inputs();
    cyc();
    check("stall_fall", 32'(cpu_stall), 32'(0));

    // Readback of the loaded image
    idx = 0; ng = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd0;
    for (int c = 0; c < 40 && ng < 16; c++) begin
      cyc();
      if (cpu_rvalid) begin
        check("readback", 32'(cpu_rdata), 32'(img(ng)));
        ng++;
      end
      if (cpu_gnt) begin
        idx++;
        if (idx == 16) cpu_req = 0; else cpu_addr = 4'(idx);
      end
    end
    check("readback_count", 32'(ng), 32'(16));
    idle_inputs();
    cyc();

    // Reset right after a granted read drops the read
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    cyc();
    check("rstrd_gnt", 32'(cpu_gnt), 32'(1));
    cpu_req = 0;
    @(posedge clk);
    reset = 0;
    model_reset();
    #1 check("rstrd_rvalid", 32'(cpu_rvalid), 32'(0));
    @(negedge clk);
    check_all();
    reset = 1;
    repeat (3) cyc();
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd5;
    cyc();
    cpu_req = 0;
    cyc();
    check("rerd_rvalid", 32'(cpu_rvalid), 32'(1));
    check("rerd_rdata", 32'(cpu_rdata), 32'(img(5)));
    cyc();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      cyc();
      if (cpu_req ? (e_cpu_gnt && $urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0)) begin
        cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = 4'($urandom_range(0, 15)); cpu_wdata = 8'($urandom);
      end else if (cpu_req && e_cpu_gnt) cpu_req = 0;
      if (ldr_req ? (e_ldr_gnt && $urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0)) begin
        ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
        ldr_addr = 4'($urandom_range(0, 15)); ldr_wdata = 8'($urandom);
      end else if (ldr_req && e_ldr_gnt) ldr_req = 0;
      if ($urandom_range(0, 15) == 0) ldr_lock = ~ldr_lock;
    end

    // Asynchronous reset in the middle of traffic clears outputs at once
    cpu_req = 1; cpu_we = 0; ldr_req = 1; ldr_we = 0; ldr_lock = 1;
    cyc();
    #2 reset = 0;
    model_reset();
    #1 check_all();
    check("rst_run_addr", 32'(mem_addr), 32'(0));
    check("rst_run_wdata", 32'(mem_wdata), 32'(0));
    idle_inputs();
    @(negedge clk);
    reset = 1;
    repeat (4) cyc();

    // Contention statistics
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 4'd7;
    ldr_req = 1; ldr_we = 0; ldr_addr = 4'd8;
    repeat (10) cyc();
    idle_inputs();
    repeat (3) cyc();
`ifdef ARB_STATS_EN
    check("conflict_10", 32'(conflict_cnt), 32'(10));
`else
    check("conflict_off", 32'(conflict_cnt), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
